// File: rtl/uart_step_sequencer.sv
// uart_step_sequencer: UART-driven debug sequencer that loads testWord, single-steps testClock and replies with probe.
module uart_step_sequencer #(
  parameter int unsigned STEP_LOW_CYCLES = 1,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RXbuffer,
  input  logic        RXready,
  input  logic        TXbusy,
  input  logic [15:0] probe,
  output logic [7:0]  TXbuffer,
  output logic        TXstart,
  output logic [31:0] testWord,
  output logic        testClock,
  output logic        busy,
  output logic        cmdError
);
  typedef enum logic [2:0] {IDLE, LOAD, COUNT, STEP_LOW, STEP_HIGH, TX_SEND, TX_WAIT} state_t;
  state_t state, nxt;
  logic [1:0]  byte_idx;
  logic [23:0] shadow;
  logic [7:0]  steps;
  logic [31:0] low_cnt, tmo_cnt;
  logic [15:0] reply;
  logic        tx_idx, tx_last, low_done, tmo_hit;
  assign low_done = low_cnt == STEP_LOW_CYCLES - 1;
  assign tmo_hit = (state == LOAD || state == COUNT) && !RXready && TIMEOUT != 0 && tmo_cnt + 32'd1 == TIMEOUT;

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = !RXready ? IDLE : RXbuffer == 8'h4C ? LOAD : RXbuffer == 8'h53 ? COUNT :
                       RXbuffer == 8'h52 ? TX_SEND : IDLE;
      LOAD:      nxt = tmo_hit ? IDLE : (RXready && byte_idx == 2'd3) ? STEP_LOW : LOAD;
      COUNT:     nxt = tmo_hit ? IDLE : !RXready ? COUNT : RXbuffer == 8'd0 ? TX_SEND : STEP_LOW;
      STEP_LOW:  nxt = low_done ? STEP_HIGH : STEP_LOW;
      STEP_HIGH: nxt = steps == 8'd1 ? TX_SEND : STEP_LOW;
      TX_SEND:   nxt = TXbusy ? TX_SEND : TX_WAIT;
      TX_WAIT:   nxt = (TXstart || TXbusy) ? TX_WAIT : tx_idx == tx_last ? IDLE : TX_SEND;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    testClock = state != STEP_LOW;
    busy = state != IDLE;
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      TXbuffer <= '0;
      TXstart  <= 1'b0;
      testWord <= '0;
      cmdError <= 1'b0;
      byte_idx <= '0;
      shadow   <= '0;
      steps    <= '0;
      low_cnt  <= '0;
      tmo_cnt  <= '0;
      reply    <= '0;
      tx_idx   <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      TXstart  <= 1'b0;
      cmdError <= 1'b0;
      case (state)
        IDLE: if (RXready) begin
          byte_idx <= '0;
          tmo_cnt  <= '0;
          low_cnt  <= '0;
          tx_idx   <= 1'b0;
          tx_last  <= RXbuffer != 8'h4C;
          if (RXbuffer == 8'h52) reply <= probe;
          else if (RXbuffer != 8'h4C && RXbuffer != 8'h53) begin
            TXstart  <= 1'b1;
            TXbuffer <= 8'h15;
            cmdError <= 1'b1;
          end
        end
        LOAD, COUNT: if (RXready) begin
          tmo_cnt  <= '0;
          shadow   <= {RXbuffer, shadow[23:8]};
          byte_idx <= byte_idx + 2'd1;
          steps    <= state == LOAD ? 8'd1 : RXbuffer;
          reply    <= probe;
          if (state == LOAD && byte_idx == 2'd3) testWord <= {RXbuffer, shadow};
        end else if (tmo_hit) cmdError <= 1'b1;
        else tmo_cnt <= tmo_cnt + 32'd1;
        STEP_LOW: low_cnt <= low_done ? '0 : low_cnt + 32'd1;
        STEP_HIGH: begin
          steps <= steps - 8'd1;
          if (steps == 8'd1) reply <= probe;
        end
        TX_SEND: if (!TXbusy) begin
          TXstart  <= 1'b1;
          TXbuffer <= tx_idx ? reply[15:8] : reply[7:0];
        end
        TX_WAIT: if (!TXstart && !TXbusy) tx_idx <= 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_uart_step_sequencer.sv
// tb_uart_step_sequencer: directed checks of framing, stepping, reply handshake, timeout and reset.
module tb_uart_step_sequencer;
  logic        CLK = 0, RST = 1, RXready = 0, TXstart, testClock, busy, cmdError;
  logic [7:0]  RXbuffer = 0, TXbuffer;
  logic [15:0] probe, probe_set = 0, step_n = 0;
  logic [31:0] testWord;
  logic        auto_p = 0, hold_busy = 0, model_busy, TXbusy, prev_start = 0;
  int          tl, pulses = 0, low_cyc = 0, wide = 0, n_chk = 0, n_pass = 0;
  int          p0, l0, n0, starts;
  logic [7:0]  txq[$];

  assign probe = auto_p ? step_n : probe_set;
  assign TXbusy = model_busy | hold_busy;

  uart_step_sequencer #(.STEP_LOW_CYCLES(1), .TIMEOUT(100)) dut (
    .CLK(CLK), .RST(RST), .RXbuffer(RXbuffer), .RXready(RXready), .TXbusy(TXbusy),
    .probe(probe), .TXbuffer(TXbuffer), .TXstart(TXstart), .testWord(testWord),
    .testClock(testClock), .busy(busy), .cmdError(cmdError));

  always #5 CLK = ~CLK;

  // Transmitter model: busy from the cycle after TXstart is sampled, for 5 cycles
  always @(posedge CLK or posedge RST)
    if (RST) begin
      model_busy <= 0;
      tl <= 0;
    end else if (TXstart) begin
      txq.push_back(TXbuffer);
      model_busy <= 1;
      tl <= 5;
    end else if (tl > 0) begin
      tl <= tl - 1;
      if (tl == 1) model_busy <= 0;
    end

  always @(posedge testClock) step_n <= auto_p ? step_n + 16'd1 : 16'd0;
  always @(negedge testClock) pulses++;
  always @(negedge CLK) begin
    if (!testClock) low_cyc++;
    if (TXstart && prev_start) wide++;
    prev_start = TXstart;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RXbuffer = b;
    RXready = 1;
    @(posedge CLK);
    #1 RXready = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge CLK);
    chk("idle_bound", busy, 0);
  endtask

  task automatic mark();
    p0 = pulses;
    l0 = low_cyc;
    n0 = txq.size();
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RST = 0;
    repeat (100) @(negedge CLK);
    chk("rst_clk", testClock, 1);
    chk("rst_txstart", TXstart, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word", testWord, 0);
    chk("rst_err", cmdError, 0);
    chk("rst_txbuf", TXbuffer, 0);

    probe_set = 16'hBEEF;
    mark();
    send(8'h4C); send(8'h78); send(8'h56); send(8'h34);
    chk("l_word_pre", testWord, 0);
    send(8'h12);
    chk("l_word", testWord, 32'h12345678);
    chk("l_clk_low", testClock, 0);
    @(posedge CLK); #1 chk("l_clk_high", testClock, 1);
    @(posedge CLK); #1 chk("l_start_early", TXstart, 0);
    @(posedge CLK); #1 chk("l_start", TXstart, 1);
    chk("l_txbuf", TXbuffer, 8'hEF);
    wait_idle();
    chk("l_pulses", pulses - p0, 1);
    chk("l_lowcyc", low_cyc - l0, 1);
    chk("l_ntx", txq.size() - n0, 1);
    chk("l_byte", txq[n0], 8'hEF);

    auto_p = 1;
    mark();
    send(8'h53); send(8'h03);
    wait_idle();
    auto_p = 0;
    chk("s3_pulses", pulses - p0, 3);
    chk("s3_lowcyc", low_cyc - l0, 3);
    chk("s3_ntx", txq.size() - n0, 2);
    chk("s3_lo", txq[n0], 8'h03);
    chk("s3_hi", txq[n0+1], 8'h00);

    probe_set = 16'h1234;
    mark();
    send(8'h53); send(8'h00);
    wait_idle();
    chk("s0_pulses", pulses - p0, 0);
    chk("s0_lo", txq[n0], 8'h34);
    chk("s0_hi", txq[n0+1], 8'h12);

    hold_busy = 1;
    probe_set = 16'hA55A;
    mark();
    starts = 0;
    send(8'h52);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (TXstart) starts++;
      RXready = i == 20;
      RXbuffer = 8'h4C;
    end
    RXready = 0;
    chk("r_hold_starts", starts, 0);
    chk("r_hold_busy", busy, 1);
    hold_busy = 0;
    wait_idle();
    chk("r_ntx", txq.size() - n0, 2);
    chk("r_lo", txq[n0], 8'h5A);
    chk("r_hi", txq[n0+1], 8'hA5);
    chk("r_word", testWord, 32'h12345678);

    mark();
    send(8'h4C); send(8'h11);
    repeat (99) @(posedge CLK);
    #1 chk("tmo_early_err", cmdError, 0);
    chk("tmo_early_busy", busy, 1);
    @(posedge CLK); #1 chk("tmo_err", cmdError, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_word", testWord, 32'h12345678);
    @(posedge CLK); #1 chk("tmo_err_pulse", cmdError, 0);
    chk("tmo_ntx", txq.size() - n0, 0);

    mark();
    send(8'h99);
    chk("bad_err", cmdError, 1);
    chk("bad_start", TXstart, 1);
    chk("bad_txbuf", TXbuffer, 8'h15);
    chk("bad_busy", busy, 0);
    @(posedge CLK); #1 chk("bad_err_pulse", cmdError, 0);
    repeat (10) @(negedge CLK);
    chk("bad_ntx", txq.size() - n0, 1);
    chk("bad_byte", txq[n0], 8'h15);

    mark();
    send(8'h53); send(8'hFF);
    wait_idle();
    chk("s255_pulses", pulses - p0, 255);
    chk("s255_ntx", txq.size() - n0, 2);

    send(8'h53); send(8'h05);
    chk("ar_pre_clk", testClock, 0);
    #2 RST = 1;
    #1 chk("ar_clk", testClock, 1);
    chk("ar_busy", busy, 0);
    chk("ar_start", TXstart, 0);
    chk("ar_word", testWord, 0);
    chk("ar_err", cmdError, 0);
    @(negedge CLK);
    RST = 0;
    probe_set = 16'h0F0E;
    mark();
    send(8'h52);
    wait_idle();
    chk("ar_r_ntx", txq.size() - n0, 2);
    chk("ar_r_lo", txq[n0], 8'h0E);
    chk("ar_r_hi", txq[n0+1], 8'h0F);
    chk("tx_wide", wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
